digit_scan_controller: RTL and testbench

Time-multiplexing scheduler for the clock's 4-digit display. It steps a 2-bit digit index through digits 0..3 at a fixed refresh rate, presents the matching BCD nibble, and gates the digit enable for PWM brightness plus an anti-ghosting dark phase. Its `digit_sel` output drives the 2-to-4 one-hot digit decoder, and `digit_bcd` feeds the segment decoder.

---
 rtl/digit_scan_controller_pkg.sv | 8 +
 rtl/digit_scan_controller_if.sv | 18 +
 rtl/digit_scan_controller_prescaler.sv | 21 ++
 rtl/digit_scan_controller.sv | 108 ++++++++++
 tb/tb_digit_scan_controller.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/digit_scan_controller_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
package display_pkg;
  typedef enum logic {IDLE, SCAN} state_t;

  localparam int         NUM_DIGITS  = 4;
  localparam int         NUM_PHASES  = 8;
  localparam logic [2:0] GUARD_PHASE = 3'd7;
endpackage

// File: rtl/digit_scan_controller_if.sv
// Control inputs and display outputs of the digit scan controller.
interface digit_scan_if;
  import display_pkg::*;

  logic                      enable;
  logic [NUM_DIGITS*4-1:0]   digit_values;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [2:0]                brightness;
  logic [1:0]                digit_sel;
  logic [3:0]                digit_bcd;
  logic                      digit_on;
  logic                      frame_done;

  modport master (output enable, digit_values, blank_mask, brightness,
                  input  digit_sel, digit_bcd, digit_on, frame_done);
  modport slave  (input  enable, digit_values, blank_mask, brightness,
                  output digit_sel, digit_bcd, digit_on, frame_done);
endinterface

// File: rtl/digit_scan_controller_prescaler.sv
// Free-running STEP_CYCLES divider with synchronous clear; reusable for colon blink.
module scan_prescaler #(
  parameter int STEP_CYCLES = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic step_tick
);
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CW-1:0] step_cnt;

  assign step_tick = (step_cnt == CW'(STEP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)   step_cnt <= '0;
    else if (step_tick) step_cnt <= '0;
    else                step_cnt <= step_cnt + 1'b1;
  end
endmodule

// File: rtl/digit_scan_controller.sv
// Digit multiplex scheduler: slot/phase counters, frame-latched shadows, PWM gating.
module digit_scan_controller
  import display_pkg::*;
#(
  parameter int STEP_CYCLES = 12500
) (
  input  logic         clk,
  input  logic         reset,
  digit_scan_if.slave  scan
);
  state_t                      state_q, state_d;
  logic [1:0]                  slot_q, slot_d;
  logic [2:0]                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0][3:0]  sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]       sh_blank_q, sh_blank_d;
  logic [2:0]                  sh_bright_q, sh_bright_d;
  logic                        frame_d, on_d, step_tick, pre_clr;
  logic [1:0]                  sel_r;
  logic [3:0]                  bcd_r;
  logic                        on_r, frame_r;

  // Prescaler held clear in IDLE and on the start edge so phase 0 gets a full step.
  assign pre_clr = !(state_q == SCAN && scan.enable);

  scan_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_pre (
    .clk       (clk),
    .reset     (reset),
    .clr       (pre_clr),
    .step_tick (step_tick)
  );

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    phase_d     = phase_q;
    sh_val_d    = sh_val_q;
    sh_blank_d  = sh_blank_q;
    sh_bright_d = sh_bright_q;
    frame_d     = 1'b0;
    case (state_q)
      IDLE: begin
        slot_d  = '0;
        phase_d = '0;
        if (scan.enable) begin
          state_d     = SCAN;
          sh_val_d    = scan.digit_values;
          sh_blank_d  = scan.blank_mask;
          sh_bright_d = scan.brightness;
        end
      end
      SCAN: begin
        if (!scan.enable) begin
          state_d = IDLE;
          slot_d  = '0;
          phase_d = '0;
        end else if (step_tick) begin
          if (phase_q == GUARD_PHASE) begin
            phase_d = '0;
            slot_d  = slot_q + 2'd1;
            // Frame wrap: inputs only take effect here, so a frame never tears.
            if (slot_q == 2'(NUM_DIGITS - 1)) begin
              frame_d     = 1'b1;
              sh_val_d    = scan.digit_values;
              sh_blank_d  = scan.blank_mask;
              sh_bright_d = scan.brightness;
            end
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    on_d = (state_d == SCAN) && !sh_blank_d[slot_d] &&
           (phase_d <= sh_bright_d) && (phase_d != GUARD_PHASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      phase_q     <= '0;
      sh_val_q    <= '0;
      sh_blank_q  <= '0;
      sh_bright_q <= '0;
      sel_r       <= '0;
      bcd_r       <= '0;
      on_r        <= 1'b0;
      frame_r     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      sh_val_q    <= sh_val_d;
      sh_blank_q  <= sh_blank_d;
      sh_bright_q <= sh_bright_d;
      sel_r       <= slot_d;
      bcd_r       <= sh_val_d[slot_d];
      on_r        <= on_d;
      frame_r     <= frame_d;
    end
  end

  assign scan.digit_sel  = sel_r;
  assign scan.digit_bcd  = bcd_r;
  assign scan.digit_on   = on_r;
  assign scan.frame_done = frame_r;
endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller with STEP_CYCLES=2 (16-cycle slot, 64-cycle frame).
module tb_digit_scan_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  digit_scan_if bus ();

  digit_scan_controller #(.STEP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .scan  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded, want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Samples one 16-cycle slot starting at the current negedge; ends at the next slot's first negedge.
  task automatic meas_slot(output int sel0, output int bcd0, output int on_n,
                           output int fd_first, output int fd_n, output int unstable);
    sel0     = int'(bus.digit_sel);
    bcd0     = int'(bus.digit_bcd);
    fd_first = int'(bus.frame_done);
    on_n     = 0;
    fd_n     = 0;
    unstable = 0;
    for (int i = 0; i < 16; i++) begin
      if (bus.digit_on)   on_n++;
      if (bus.frame_done) fd_n++;
      if (int'(bus.digit_sel) != sel0 || int'(bus.digit_bcd) != bcd0) unstable++;
      @(negedge clk);
    end
  endtask

  initial begin
    int sel0, bcd0, on_n, fd_first, fd_n, unst, tot;
    int bexp [8] = '{2, 4, 6, 8, 10, 12, 14, 14};
    int blexp[4] = '{14, 14, 0, 14};

    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.digit_values = 16'h4321;
    bus.blank_mask   = 4'b0000;
    bus.brightness   = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst_sel",   int'(bus.digit_sel),  0);
    chk("rst_bcd",   int'(bus.digit_bcd),  0);
    chk("rst_on",    int'(bus.digit_on),   0);
    chk("rst_frame", int'(bus.frame_done), 0);

    // First frame after enable: no frame_done on start-up
    reset      = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
      chk($sformatf("f1_sel%0d", k),    sel0, k);
      chk($sformatf("f1_bcd%0d", k),    bcd0, k + 1);
      chk($sformatf("f1_on%0d", k),     on_n, 14);
      chk($sformatf("f1_stable%0d", k), unst, 0);
      chk($sformatf("f1_fd%0d", k),     fd_n, 0);
    end
    meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
    chk("f2_fd_first", fd_first, 1);
    chk("f2_fd_count", fd_n, 1);
    chk("f2_sel0",     sel0, 0);
    chk("f2_bcd0",     bcd0, 1);
    for (int k = 1; k < 4; k++) meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);

    // Brightness sweep: new value set at frame start shows in the following frame
    for (int b = 0; b < 8; b++) begin
      bus.brightness = 3'(b);
      for (int k = 0; k < 4; k++) meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
      tot = 0;
      for (int k = 0; k < 4; k++) begin
        meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
        tot += on_n;
      end
      chk($sformatf("bright%0d_on", b), tot, 4 * bexp[b]);
    end

    // Blank digit 2
    bus.blank_mask = 4'b0100;
    for (int k = 0; k < 4; k++) meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
    bus.blank_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
      chk($sformatf("blank_on%0d", k), on_n, blexp[k]);
    end

    // Mid-slot-1 data change must not tear the current frame
    meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
    chk("tear_bcd0", bcd0, 1);
    chk("tear_sel1", int'(bus.digit_sel), 1);
    repeat (8) @(negedge clk);
    bus.digit_values = 16'h8765;
    @(negedge clk);
    chk("tear_bcd1_mid", int'(bus.digit_bcd), 2);
    repeat (7) @(negedge clk);
    for (int k = 2; k < 4; k++) begin
      meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
      chk($sformatf("tear_bcd%0d", k), bcd0, k + 1);
    end
    for (int k = 0; k < 4; k++) begin
      meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
      chk($sformatf("new_bcd%0d", k), bcd0, k + 5);
      if (k == 0) chk("new_fd_first", fd_first, 1);
    end

    // Disable in slot 2 phase 3, then re-enable
    for (int k = 0; k < 2; k++) meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
    repeat (6) @(negedge clk);
    chk("dis_pre_sel", int'(bus.digit_sel), 2);
    chk("dis_pre_on",  int'(bus.digit_on),  1);
    bus.enable = 1'b0;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tot += int'(bus.digit_on) + int'(bus.digit_sel) + int'(bus.frame_done);
    end
    chk("dis_outputs_dark", tot, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("reen_sel", int'(bus.digit_sel),  0);
    chk("reen_bcd", int'(bus.digit_bcd),  5);
    chk("reen_on",  int'(bus.digit_on),   1);
    chk("reen_fd",  int'(bus.frame_done), 0);
    meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);
    chk("reen_slot0_on", on_n, 14);
    for (int k = 1; k < 3; k++) meas_slot(sel0, bcd0, on_n, fd_first, fd_n, unst);

    // Reset during slot 3 with enable still high
    repeat (4) @(negedge clk);
    chk("prerst_sel", int'(bus.digit_sel), 3);
    reset            = 1'b1;
    bus.digit_values = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_out%0d", i),
          int'({bus.digit_sel, bus.digit_bcd, bus.digit_on, bus.frame_done}), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_sel", int'(bus.digit_sel), 0);
    chk("postrst_bcd", int'(bus.digit_bcd), 9);
    chk("postrst_on",  int'(bus.digit_on),  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
